sll_iter: RTL and testbench

- Multi-cycle logical left shifter for the ALU; it performs SLL, the opposite direction to the fixed right-shift stages.
- It accepts an operand and a 5-bit shift amount over a valid/ready handshake.
- It applies one binary-weighted shift stage per clock (16, 8, 4, 2, 1), then returns the result over a second valid/ready handshake.
- Intended for area-constrained ALU builds that drop the full barrel shifter.

---
 rtl/alu_shift_pkg.sv | 8 +
 rtl/sll_stage.sv | 12 +
 rtl/sll_iter.sv | 67 ++++++
 tb/tb_sll_iter.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: shared constants and state type for the iterative ALU shifters
package alu_shift_pkg;
  localparam int WIDTH = 32;
  localparam int SHAMT_W = 5;
  localparam int LATENCY = SHAMT_W;
  localparam int OP_CYCLES = SHAMT_W + 2;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/sll_stage.sv
// sll_stage: one binary-weighted left-shift stage, distance 2**idx when enabled
module sll_stage #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] acc_in,
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] acc_out
);
  always_comb acc_out = en ? acc_in << (32'd1 << idx) : acc_in;
endmodule

// File: rtl/sll_iter.sv
// sll_iter: multi-cycle logical left shifter, one binary-weighted stage per clock
module sll_iter #(
  parameter int WIDTH = alu_shift_pkg::WIDTH,
  parameter int SHAMT_W = alu_shift_pkg::SHAMT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);
  import alu_shift_pkg::state_e, alu_shift_pkg::IDLE, alu_shift_pkg::SHIFT, alu_shift_pkg::DONE;
  localparam int IDX_W = $clog2(SHAMT_W);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d, stage_out;
  logic [SHAMT_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  sll_stage #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_stage (
    .acc_in (acc_q),
    .idx    (idx_q),
    .en     (sh_q[idx_q]),
    .acc_out(stage_out)
  );
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = acc_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        acc_d   = in_data;
        sh_d    = in_shamt;
        idx_d   = IDX_W'(SHAMT_W - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d   = stage_out;
        idx_d   = idx_q - IDX_W'(1);
        state_d = idx_q == '0 ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      idx_q   <= IDX_W'(SHAMT_W - 1);
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_sll_iter.sv
// tb_sll_iter: directed and randomized checks of sll_iter against a shift reference model
module tb_sll_iter;
  logic        clock = 0, reset_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [4:0]  in_shamt = 0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  int n_cmp = 0, n_bad = 0;

  sll_iter dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge with the block idle; returns at the negedge after the output handshake.
  task automatic do_op(input logic [31:0] d, input logic [4:0] s, input int stall,
                       input logic hold, input logic [31:0] nd, input logic [4:0] ns);
    logic [31:0] exp;
    int lat, bsy;
    exp = d << s;
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1; in_data = d; in_shamt = s; out_ready = 0;
    @(negedge clock);
    lat = 0; bsy = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_shift", in_ready, 1'b0);
      if (busy) bsy++;
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; in_shamt = 5'($urandom);
      @(negedge clock);
      lat++;
    end
    chk("latency", lat, 5);
    chk("out_valid", out_valid, 1'b1);
    chk("result", out_data, exp);
    in_valid = hold; in_data = nd; in_shamt = ns;
    for (int i = 0; i < stall; i++) begin
      if (busy) bsy++;
      @(negedge clock);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, exp);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    if (busy) bsy++;
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
    chk("busy_cycles", bsy, 6 + stall);
    chk("post_valid", out_valid, 1'b0);
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_busy", busy, 1'b0);
    chk("post_data", out_data, exp);
    if (!hold) in_valid = 0;
  endtask

  initial begin
    int seen;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    do_op(32'h0000_0001, 5'd31, 0, 0, 0, 0);
    do_op(32'hDEAD_BEEF, 5'd0, 0, 0, 0, 0);
    do_op(32'hFFFF_FFFF, 5'd13, 0, 0, 0, 0);
    do_op(32'h1234_5678, 5'd4, 10, 1, 32'hAAAA_AAAA, 5'd3);
    do_op(32'hAAAA_AAAA, 5'd3, 0, 0, 0, 0);
    // abort an operation partway through SHIFT
    in_valid = 1; in_data = 32'h0000_00F0; in_shamt = 5'd8;
    @(negedge clock);
    in_valid = 0;
    @(negedge clock);
    reset_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_data", out_data, 32'h0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge clock);
    reset_n = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid || busy) seen++;
    end
    chk("abort_no_output", seen, 0);
    for (int s = 0; s < 32; s++) do_op(32'h8000_0001, 5'(s), 0, 0, 0, 0);
    for (int k = 0; k < 40; k++)
      do_op($urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
